// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one byte-wide synchronous-read memory between the CPU port and the
// loader/debug port: round-robin by default, with a bounded bus lock for loader bursts.
module mem_port_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int MAX_LOCK = 8
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [7:0]        cpu_rdata,

    input  logic              ld_req,
    input  logic              ld_we,
    input  logic              ld_lock,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_wdata,
    output logic              ld_gnt,
    output logic              ld_rvalid,
    output logic [7:0]        ld_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic {ARB, LOCK} state_t;

    localparam logic [7:0] LOCK_LIMIT = 8'(MAX_LOCK);

    state_t     state, state_nxt;
    logic       last_gnt, last_gnt_nxt;   // 0 = CPU, 1 = loader
    logic [7:0] lock_cnt, lock_cnt_nxt;
    logic       rd_valid, rd_owner;       // owner: 0 = CPU, 1 = loader
    logic       rr_cpu, rr_ld;
    logic       rd_issue;

    // Fair choice used in ARB and on the cycle a lock is released.
    always_comb begin
        rr_cpu = 1'b0;
        rr_ld  = 1'b0;
        if (cpu_req && ld_req) begin
            rr_cpu = last_gnt;
            rr_ld  = ~last_gnt;
        end else begin
            rr_cpu = cpu_req;
            rr_ld  = ld_req;
        end
    end

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        cpu_gnt      = 1'b0;
        ld_gnt       = 1'b0;
        state_nxt    = state;
        lock_cnt_nxt = lock_cnt;

        case (state)
            ARB: begin
                cpu_gnt      = rr_cpu;
                ld_gnt       = rr_ld;
                lock_cnt_nxt = 8'd0;
                if (rr_ld && ld_lock)
                    state_nxt = LOCK;
            end
            LOCK: begin
                if (!ld_lock) begin
                    cpu_gnt      = rr_cpu;
                    ld_gnt       = rr_ld;
                    lock_cnt_nxt = 8'd0;
                    state_nxt    = ARB;
                end else if (ld_req) begin
                    // A starved CPU is forced one grant once the budget is spent.
                    if (cpu_req && lock_cnt >= LOCK_LIMIT) begin
                        cpu_gnt      = 1'b1;
                        lock_cnt_nxt = 8'd0;
                    end else begin
                        ld_gnt = 1'b1;
                        if (!cpu_req)
                            lock_cnt_nxt = 8'd0;
                        else if (lock_cnt != 8'hFF)
                            lock_cnt_nxt = lock_cnt + 8'd1;
                    end
                end else begin
                    cpu_gnt      = cpu_req;
                    lock_cnt_nxt = 8'd0;
                end
            end
            default: begin
                state_nxt    = ARB;
                lock_cnt_nxt = 8'd0;
            end
        endcase

        // No memory access may be issued while the arbiter is held in reset.
        if (reset) begin
            cpu_gnt = 1'b0;
            ld_gnt  = 1'b0;
        end
    end

    always_comb begin
        last_gnt_nxt = last_gnt;
        if (cpu_gnt)
            last_gnt_nxt = 1'b0;
        else if (ld_gnt)
            last_gnt_nxt = 1'b1;
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ARB;
            last_gnt <= 1'b1;
            lock_cnt <= 8'd0;
        end else begin
            state    <= state_nxt;
            last_gnt <= last_gnt_nxt;
            lock_cnt <= lock_cnt_nxt;
        end
    end

    assign mem_en = cpu_gnt | ld_gnt;

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = 8'd0;
        if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (ld_gnt) begin
            mem_we    = ld_we;
            mem_addr  = ld_addr;
            mem_wdata = ld_wdata;
        end
    end

    assign rd_issue = mem_en & ~mem_we;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_owner <= 1'b0;
        end else begin
            rd_valid <= rd_issue;
            if (rd_issue)
                rd_owner <= ld_gnt;
        end
    end

    assign cpu_rvalid = rd_valid & ~rd_owner;
    assign ld_rvalid  = rd_valid & rd_owner;
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : 8'd0;
    assign ld_rdata   = ld_rvalid ? mem_rdata : 8'd0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic, all checked
// against a transaction-level model of grants, lock budget and read returns.
module tb_mem_port_arbiter;

    localparam int AW   = 8;
    localparam int MAXL = 8;

    typedef struct packed {
        logic          cpu_gnt;
        logic          ld_gnt;
        logic          mem_en;
        logic          mem_we;
        logic [AW-1:0] mem_addr;
        logic [7:0]    mem_wdata;
        logic          cpu_rvalid;
        logic [7:0]    cpu_rdata;
        logic          ld_rvalid;
        logic [7:0]    ld_rdata;
    } snap_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_wdata, cpu_rdata;
    logic          ld_req, ld_we, ld_lock, ld_gnt, ld_rvalid;
    logic [AW-1:0] ld_addr;
    logic [7:0]    ld_wdata, ld_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata = 8'd0;

    logic [7:0] mem    [256];
    logic [7:0] shadow [256];

    int    total = 0;
    int    bad   = 0;
    snap_t obs, exp;

    // Transaction-level model state.
    bit         m_locked;
    bit         m_last_ld;
    int         m_waits;
    bit         m_rd_pend;
    bit         m_rd_ld;
    logic [7:0] m_rd_data;

    mem_port_arbiter #(.ADDR_W(AW), .MAX_LOCK(MAXL)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .ld_req(ld_req), .ld_we(ld_we), .ld_lock(ld_lock), .ld_addr(ld_addr),
        .ld_wdata(ld_wdata), .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(int i);
        return (i == 16) ? 8'hA5 : 8'(i * 7 + 3);
    endfunction

    // Synchronous-read memory; contents are never touched by reset.
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = init_val(i);
        forever begin
            @(posedge clk);
            if (mem_en) begin
                if (mem_we) mem[mem_addr] <= mem_wdata;
                else        mem_rdata     <= mem[mem_addr];
            end
        end
    end

    function automatic snap_t snap();
        return {cpu_gnt, ld_gnt, mem_en, mem_we, mem_addr, mem_wdata,
                cpu_rvalid, cpu_rdata, ld_rvalid, ld_rdata};
    endfunction

    // Winner: 0 = nobody, 1 = CPU, 2 = loader.
    function automatic int pick(bit cr, bit lr, bit lk);
        if (m_locked && lk) begin
            if (lr) return (cr && m_waits >= MAXL) ? 1 : 2;
            return cr ? 1 : 0;
        end
        if (cr && lr) return m_last_ld ? 1 : 2;
        if (cr) return 1;
        if (lr) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        m_locked  = 1'b0;
        m_last_ld = 1'b1;
        m_waits   = 0;
        m_rd_pend = 1'b0;
        m_rd_ld   = 1'b0;
        m_rd_data = 8'd0;
    endtask

    task automatic idle_inputs();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = 8'd0;
        ld_req  = 1'b0; ld_we  = 1'b0; ld_lock  = 1'b0; ld_addr = '0; ld_wdata = 8'd0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    // One clock: fill obs/exp mid-cycle, then advance the model across the edge.
    task automatic cycle(output int win);
        bit            cr, lk, was_locked, we;
        logic [AW-1:0] a;
        logic [7:0]    d;
        @(negedge clk);
        cr         = cpu_req;
        lk         = ld_lock;
        was_locked = m_locked;
        win        = pick(cpu_req, ld_req, ld_lock);
        we = (win == 1) ? cpu_we    : (win == 2) ? ld_we    : 1'b0;
        a  = (win == 1) ? cpu_addr  : (win == 2) ? ld_addr  : '0;
        d  = (win == 1) ? cpu_wdata : (win == 2) ? ld_wdata : 8'd0;
        exp.cpu_gnt    = (win == 1);
        exp.ld_gnt     = (win == 2);
        exp.mem_en     = (win != 0);
        exp.mem_we     = we;
        exp.mem_addr   = a;
        exp.mem_wdata  = d;
        exp.cpu_rvalid = m_rd_pend && !m_rd_ld;
        exp.cpu_rdata  = (m_rd_pend && !m_rd_ld) ? m_rd_data : 8'd0;
        exp.ld_rvalid  = m_rd_pend && m_rd_ld;
        exp.ld_rdata   = (m_rd_pend && m_rd_ld) ? m_rd_data : 8'd0;
        obs = snap();
        @(posedge clk);
        m_rd_pend = 1'b0;
        if (win != 0) begin
            if (we) shadow[a] = d;
            else begin
                m_rd_pend = 1'b1;
                m_rd_ld   = (win == 2);
                m_rd_data = shadow[a];
            end
            m_last_ld = (win == 2);
        end
        if (!was_locked) begin
            if (win == 2 && lk) begin
                m_locked = 1'b1;
                m_waits  = 0;
            end
        end else if (!lk)            m_locked = 1'b0;
        else if (win == 2 && cr)     m_waits  = (m_waits < 255) ? m_waits + 1 : 255;
        else                         m_waits  = 0;
        #1;
    endtask

    task automatic test_reset();
        int win;
        idle_inputs();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        obs = snap();
        total++;
        if (obs !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0", obs);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();

        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
        cycle(win);
        total++;
        if ({obs.cpu_gnt, obs.mem_en, obs.mem_we, obs.mem_addr} !== {1'b1, 1'b1, 1'b0, 8'h10}) begin
            bad++;
            $display("FAIL cpu_read_grant got=%b%b%b/%h want=110/10", obs.cpu_gnt, obs.mem_en, obs.mem_we, obs.mem_addr);
        end
        cpu_req = 1'b0;
        cycle(win);
        total++;
        if ({obs.cpu_rvalid, obs.cpu_rdata, obs.ld_rvalid} !== {1'b1, 8'hA5, 1'b0}) begin
            bad++;
            $display("FAIL cpu_read_return got=%b/%h/%b want=1/a5/0", obs.cpu_rvalid, obs.cpu_rdata, obs.ld_rvalid);
        end
    endtask

    task automatic test_alternation();
        int win;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'(i);
            ld_req  = 1'b1; ld_we  = 1'b0; ld_addr  = 8'(i + 64);
            cycle(win);
            total++;
            if ({obs.cpu_gnt, obs.ld_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01) || obs !== exp) begin
                bad++;
                $display("FAIL alternation cyc=%0d got=%h want=%h", i, obs, exp);
            end
        end
        idle_inputs();
    endtask

    task automatic test_ld_write_cpu_read();
        int win;
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 8'h20; ld_wdata = 8'h3C;
        cycle(win);
        total++;
        if ({obs.ld_gnt, obs.mem_we, obs.mem_addr, obs.mem_wdata} !== {1'b1, 1'b1, 8'h20, 8'h3C}) begin
            bad++;
            $display("FAIL ld_write got=%b%b/%h/%h want=11/20/3c", obs.ld_gnt, obs.mem_we, obs.mem_addr, obs.mem_wdata);
        end
        idle_inputs();
        cpu_req = 1'b1; cpu_addr = 8'h20;
        cycle(win);
        total++;
        if (obs.cpu_gnt !== 1'b1 || obs.cpu_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL cpu_read_20_grant got=%b%b want=10", obs.cpu_gnt, obs.cpu_rvalid);
        end
        cpu_req = 1'b0;
        cycle(win);
        total++;
        if ({obs.cpu_rvalid, obs.cpu_rdata} !== {1'b1, 8'h3C}) begin
            bad++;
            $display("FAIL cpu_read_20_data got=%b/%h want=1/3c", obs.cpu_rvalid, obs.cpu_rdata);
        end
        // Same-address CPU write racing a loader read: served strictly in grant order.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h21; cpu_wdata = 8'h77;
        ld_req  = 1'b1; ld_we  = 1'b0; ld_addr  = 8'h21;
        for (int i = 0; i < 4; i++) begin
            cycle(win);
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL same_addr cyc=%0d got=%h want=%h", i, obs, exp);
            end
            if (win == 1) cpu_req = 1'b0;
            if (win == 2) ld_req  = 1'b0;
        end
        idle_inputs();
    endtask

    task automatic test_lock();
        int  win;
        bit  want_ld;
        apply_reset();
        ld_lock = 1'b1;
        for (int i = 0; i < 26; i++) begin
            if (i == 20) ld_lock = 1'b0;
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'(i);
            ld_req  = 1'b1; ld_we  = 1'b0; ld_addr  = 8'(i + 128);
            cycle(win);
            // CPU first tie, 9 loader grants (entry + 8 locked), forced CPU, 8 loader, forced CPU.
            want_ld = (i < 20) ? !(i == 0 || i == 10 || i == 19) : (i % 2 == 0);
            total++;
            if (obs.ld_gnt !== want_ld || obs.cpu_gnt !== !want_ld || obs !== exp) begin
                bad++;
                $display("FAIL lock cyc=%0d ld_gnt=%b want=%b got=%h model=%h", i, obs.ld_gnt, want_ld, obs, exp);
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_read();
        int win;
        cpu_req = 1'b1; cpu_addr = 8'h10;
        cycle(win);
        total++;
        if (obs.cpu_gnt !== 1'b1) begin
            bad++;
            $display("FAIL midreset_grant got=%b want=1", obs.cpu_gnt);
        end
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        obs = snap();
        total++;
        if (obs !== '0) begin
            bad++;
            $display("FAIL midreset_outputs got=%h want=0", obs);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        cpu_req = 1'b1; ld_req = 1'b1; ld_addr = 8'h11; cpu_addr = 8'h12;
        cycle(win);
        total++;
        if ({obs.cpu_gnt, obs.ld_gnt, obs.cpu_rvalid, obs.ld_rvalid} !== 4'b1000) begin
            bad++;
            $display("FAIL post_reset_tie got=%b%b%b%b want=1000", obs.cpu_gnt, obs.ld_gnt, obs.cpu_rvalid, obs.ld_rvalid);
        end
        idle_inputs();
        cycle(win);
    endtask

    task automatic test_back_to_back();
        int win;
        ld_req = 1'b1; ld_addr = 8'h30;
        cycle(win);
        total++;
        if (obs.ld_gnt !== 1'b1) begin
            bad++;
            $display("FAIL b2b_ld_grant got=%b want=1", obs.ld_gnt);
        end
        idle_inputs();
        cpu_req = 1'b1; cpu_addr = 8'h31;
        cycle(win);
        total++;
        if ({obs.cpu_gnt, obs.ld_rvalid, obs.ld_rdata, obs.cpu_rvalid, obs.cpu_rdata}
            !== {1'b1, 1'b1, init_val(8'h30), 1'b0, 8'h00}) begin
            bad++;
            $display("FAIL b2b_ld_return got=%b %b/%h %b/%h want=1 1/%h 0/00", obs.cpu_gnt,
                     obs.ld_rvalid, obs.ld_rdata, obs.cpu_rvalid, obs.cpu_rdata, init_val(8'h30));
        end
        idle_inputs();
        cycle(win);
        total++;
        if ({obs.cpu_rvalid, obs.cpu_rdata, obs.ld_rvalid, obs.ld_rdata}
            !== {1'b1, init_val(8'h31), 1'b0, 8'h00}) begin
            bad++;
            $display("FAIL b2b_cpu_return got=%b/%h %b/%h want=1/%h 0/00", obs.cpu_rvalid,
                     obs.cpu_rdata, obs.ld_rvalid, obs.ld_rdata, init_val(8'h31));
        end
    endtask

    task automatic test_random();
        int win;
        idle_inputs();
        for (int i = 0; i < 600; i++) begin
            if (!cpu_req && $urandom_range(0, 3) != 0) begin
                cpu_req   = 1'b1;
                cpu_we    = ($urandom_range(0, 3) == 0);
                cpu_addr  = 8'($urandom_range(0, 15));
                cpu_wdata = 8'($urandom);
            end
            if (!ld_req && $urandom_range(0, 7) != 0) begin
                ld_req   = 1'b1;
                ld_we    = ($urandom_range(0, 2) == 0);
                ld_addr  = 8'($urandom_range(0, 15));
                ld_wdata = 8'($urandom);
            end
            if ($urandom_range(0, 23) == 0) ld_lock = ~ld_lock;
            cycle(win);
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL random cyc=%0d got=%h want=%h", i, obs, exp);
            end
            if (win == 1) cpu_req = 1'b0;
            if (win == 2) ld_req  = 1'b0;
        end
        idle_inputs();
        cycle(win);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL random_drain got=%h want=%h", obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
        model_reset();
        test_reset();
        test_alternation();
        test_ld_write_cpu_read();
        test_lock();
        test_reset_mid_read();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single byte-wide unified instruction/data memory between two requesters.
- Requester 0 is the multicycle CPU port: byte fetches, lb and sb.
- Requester 1 is the loader/debug port, which fills program memory and peeks or pokes bytes.
- Sits between both requesters and the synchronous-read memory; issues at most one memory access per cycle and routes read data back to the owner.

Parameters:
- ADDR_W, 8, byte address width.
- MAX_LOCK, 8, maximum consecutive locked loader grants while the CPU is waiting before the CPU is forced one grant (range 1..255).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- cpu_req  input  1  CPU access request; held until granted.
- cpu_we  input  1  1 = write (sb), 0 = read (fetch/lb).
- cpu_addr  input  ADDR_W  CPU byte address.
- cpu_wdata  input  8  CPU write byte.
- cpu_gnt  output  1  CPU access accepted this cycle; the CPU stalls while cpu_req&~cpu_gnt.
- cpu_rvalid  output  1  CPU read data valid.
- cpu_rdata  output  8  CPU read byte.
- ld_req  input  1  loader request; held until granted.
- ld_we  input  1  loader write.
- ld_lock  input  1  loader requests bus lock for a burst.
- ld_addr  input  ADDR_W  loader byte address.
- ld_wdata  input  8  loader write byte.
- ld_gnt  output  1  loader access accepted this cycle.
- ld_rvalid  output  1  loader read data valid.
- ld_rdata  output  8  loader read byte.
- mem_en  output  1  memory access strobe.
- mem_we  output  1  memory write enable.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  8  memory write byte.
- mem_rdata  input  8  memory read byte; valid the cycle after a read strobe.

Behaviour:

Interface:
- One clock, clk. Reset is the port named reset: asynchronous and active-high.

Handshake:
- An access transfers in the cycle where req & gnt = 1.
- gnt is combinational from current requests and registered state. It is never asserted without req.
- A requester must hold addr, we and wdata stable while req & ~gnt.

Memory side (combinational from the winner):
- mem_en = cpu_gnt | ld_gnt.
- mem_we, mem_addr, mem_wdata are muxed from the granted port.
- When idle, mem_we = 0 and mem_addr/mem_wdata = 0.

Read return:
- A registered read owner is captured on a granted read. It is 0 = CPU, 1 = loader, and has a valid bit.
- Next cycle: the owner's rvalid = 1 and its rdata = mem_rdata. The other port's rdata = 0.
- Read latency is exactly 1 cycle after the grant. Writes produce no rvalid.
- Back-to-back reads return on consecutive cycles.

State machine, states ARB and LOCK. Registered: last_gnt (0 = CPU, 1 = loader) and an 8-bit lock_cnt.
- ARB, one requester: that requester is granted.
- ARB, both requesting: round-robin; the requester other than last_gnt wins. Update last_gnt on each grant.
- ARB → LOCK: on a loader grant with ld_lock = 1. lock_cnt <= 0.
- LOCK, ld_req = 1: the loader is granted.
  - If cpu_req = 1, lock_cnt increments.
  - When lock_cnt reaches MAX_LOCK with cpu_req = 1, that cycle grants the CPU instead, clears lock_cnt and stays in LOCK.
- LOCK, ld_req = 0: the CPU is granted if requesting.
- LOCK → ARB: when ld_lock = 0 is sampled (with or without ld_req). The loader is not granted that cycle if cpu_req = 1 and last_gnt = 1.
- lock_cnt saturates and only counts while cpu_req = 1. A cycle with cpu_req = 0 clears it.

Reset values:
- All outputs 0. State = ARB, last_gnt = 1 (CPU wins the first tie), lock_cnt = 0, read owner valid = 0.

Reset mid-operation:
- A pending read-return is dropped; no rvalid is produced after reset.
- The memory contents are not affected by the arbiter.

Boundary conditions:
- Simultaneous requests, no lock: strict alternation.
- A CPU write and a loader read to the same address in adjacent cycles are served in grant order; there is no forwarding.
- MAX_LOCK = 1: the CPU is interleaved every other cycle during a lock.

Test Plan:
- Reset → all outputs 0. Then cpu_req=1, cpu_we=0, cpu_addr=0x10, mem holds 0xA5 → cpu_gnt=1, mem_en=1, mem_addr=0x10; next cycle cpu_rvalid=1, cpu_rdata=0xA5, ld_rvalid=0.
- cpu_req and ld_req both held high, no lock, 6 cycles → grants alternate CPU, LD, CPU, LD, CPU, LD.
- Loader writes 0x3C to 0x20, then the CPU reads 0x20 → mem_we=1 in the loader cycle; the CPU read returns 0x3C one cycle after its grant.
- ld_lock=1, ld_req and cpu_req held high, MAX_LOCK=8 → 8 loader grants, then 1 CPU grant, then 8 loader grants. Dropping ld_lock returns to alternation.
- CPU read granted, reset asserted in the return cycle → cpu_rvalid stays 0. After reset, the first tie grants the CPU.
- Loader read and CPU read back-to-back (LD then CPU) → ld_rvalid at t+1 and cpu_rvalid at t+2, each with its own address's data and no cross-routing.
